// File: rtl/servo_pkg.sv
// Shared constants and timing helper for the servo PWM bank.
`timescale 1ns/1ps
package servo_pkg;

  // Word indexes decoded from address bits [6:2].
  localparam logic [4:0] REG_ENABLE  = 5'd0;
  localparam logic [4:0] REG_SLEW    = 5'd1;
  localparam logic [4:0] REG_FRAMES  = 5'd2;
  localparam logic [4:0] REG_TARGET0 = 5'd4;

  // Frame and pulse timing, all in clock cycles.
  typedef struct packed {
    int period;
    int min_t;
    int max_t;
    int step_t;
  } servo_timing_t;

  // A 20 ms frame with pulses from 1 ms to 2 ms, split into 255 position steps.
  function automatic servo_timing_t calc_timing(input int basetime);
    servo_timing_t t;
    t.period = basetime / 50;
    t.min_t  = basetime / 1000;
    t.max_t  = basetime / 500;
    t.step_t = (t.max_t - t.min_t) / 255;
    return t;
  endfunction

endpackage

// File: rtl/servo_if.sv
// CPU memory-bus signals seen by the servo bank.
`timescale 1ns/1ps
interface servo_if;
  logic [31:0] address_in;
  logic        sel_in;
  logic        read_in;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic        ready_out;

  modport master (
    output address_in, sel_in, read_in, write_mask_in, write_value_in,
    input  read_value_out, ready_out
  );

  modport slave (
    input  address_in, sel_in, read_in, write_mask_in, write_value_in,
    output read_value_out, ready_out
  );
endinterface

// File: rtl/servo_channel.sv
// One servo channel: target/current position, slew step, latched pulse width and pwm bit.
`timescale 1ns/1ps
module servo_channel #(
  parameter int Q_W       = 16,
  parameter int MIN_T     = 1000,
  parameter int STEP_T    = 3,
  parameter int RESET_POS = 128
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [Q_W-1:0] q_next,
  input  logic           fb,
  input  logic [7:0]     slew,
  input  logic           enable,
  input  logic           wr,
  input  logic [7:0]     wr_data,
  output logic [7:0]     target,
  output logic [7:0]     current,
  output logic           pwm
);

  localparam logic [Q_W-1:0] MIN_W       = Q_W'(MIN_T);
  localparam logic [Q_W-1:0] STEP_W      = Q_W'(STEP_T);
  localparam logic [7:0]     RESET_P8    = 8'(RESET_POS);
  localparam logic [Q_W-1:0] RESET_WIDTH = Q_W'(MIN_T + RESET_POS * STEP_T);

  logic [Q_W-1:0] width;
  logic           en_lat;
  logic [7:0]     cur_step;
  logic [7:0]     gap;
  logic [Q_W-1:0] width_calc;
  logic [Q_W-1:0] eff_width;
  logic           eff_en;

  // Position after one slew step toward target; a step never passes the target.
  always_comb begin
    cur_step = current;
    gap      = 8'd0;
    if (slew == 8'd0) begin
      cur_step = target;
    end else if (target > current) begin
      gap      = target - current;
      cur_step = (gap > slew) ? current + slew : target;
    end else if (target < current) begin
      gap      = current - target;
      cur_step = (gap > slew) ? current - slew : target;
    end
  end

  // At the frame boundary the new frame starts with the freshly latched width and
  // enable, so the very first cycle of a pulse already uses the updated values.
  always_comb begin
    width_calc = MIN_W + Q_W'(cur_step) * STEP_W;
    eff_width  = fb ? width_calc : width;
    eff_en     = fb ? enable : en_lat;
  end

  // Target takes bus writes any time; position, width and enable move only at the boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target  <= RESET_P8;
      current <= RESET_P8;
      width   <= RESET_WIDTH;
      en_lat  <= 1'b0;
      pwm     <= 1'b0;
    end else begin
      if (wr) target <= wr_data;
      if (fb) begin
        current <= cur_step;
        width   <= width_calc;
        en_lat  <= enable;
      end
      pwm <= eff_en && (q_next < eff_width);
    end
  end

endmodule

// File: rtl/servo_bank.sv
// Multi-channel RC-servo PWM generator with bus-mapped registers and frame-aligned updates.
`timescale 1ns/1ps
module servo_bank
  import servo_pkg::*;
#(
  parameter int BASETIME  = 50000000,
  parameter int NUM_CH    = 4,
  parameter int RESET_POS = 128
) (
  input  logic              clk,
  input  logic              reset,
  output logic [NUM_CH-1:0] pwm,
  output logic [7:0]        monitor,
  servo_if.slave            bus
);

  localparam servo_timing_t TIM    = calc_timing(BASETIME);
  localparam int            PERIOD = TIM.period;
  localparam int            Q_W    = $clog2(PERIOD);

  logic [Q_W-1:0]               q;
  logic [Q_W-1:0]               q_next;
  logic                         fb;
  logic [NUM_CH-1:0]            enable;
  logic [7:0]                   slew;
  logic [15:0]                  frames;
  logic [4:0]                   idx;
  logic                         wr_en;
  logic [NUM_CH-1:0]            tgt_wr;
  logic [NUM_CH-1:0][7:0]       target_vec;
  logic [NUM_CH-1:0][7:0]       current_vec;
  logic [31:0]                  rdata;
  logic                         unused_bus;

  assign idx        = bus.address_in[6:2];
  assign wr_en      = bus.sel_in && bus.write_mask_in[0];
  assign fb         = (q == Q_W'(PERIOD - 1));
  assign q_next     = fb ? '0 : q + Q_W'(1);
  assign monitor    = current_vec[0];
  assign bus.ready_out      = bus.sel_in;
  assign bus.read_value_out = rdata;
  assign unused_bus = ^{bus.address_in[31:7], bus.address_in[1:0],
                        bus.write_mask_in[3:1], bus.write_value_in[31:8]};

  // Free-running frame counter; the last count of a frame is the update boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= '0;
    else        q <= q_next;
  end

  // Control registers written through byte lane 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable <= '0;
      slew   <= 8'd0;
    end else if (wr_en) begin
      if (idx == REG_ENABLE) enable <= bus.write_value_in[NUM_CH-1:0];
      if (idx == REG_SLEW)   slew   <= bus.write_value_in[7:0];
    end
  end

  // Frame counter visible to software, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  frames <= 16'd0;
    else if (fb) frames <= frames + 16'd1;
  end

  // Per-channel target write strobes; indexes beyond the last channel hit nothing.
  always_comb begin
    tgt_wr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      tgt_wr[i] = wr_en && (idx == 5'(REG_TARGET0 + i));
    end
  end

  // Combinational readback, zero unless a read is selected or for unmapped indexes.
  always_comb begin
    rdata = 32'd0;
    if (bus.sel_in && bus.read_in) begin
      case (idx)
        REG_ENABLE: rdata[NUM_CH-1:0] = enable;
        REG_SLEW:   rdata[7:0]        = slew;
        REG_FRAMES: rdata[15:0]       = frames;
        default: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (idx == 5'(REG_TARGET0 + i)) rdata = {16'd0, current_vec[i], target_vec[i]};
          end
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    servo_channel #(
      .Q_W      (Q_W),
      .MIN_T    (TIM.min_t),
      .STEP_T   (TIM.step_t),
      .RESET_POS(RESET_POS)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .q_next (q_next),
      .fb     (fb),
      .slew   (slew),
      .enable (enable[g]),
      .wr     (tgt_wr[g]),
      .wr_data(bus.write_value_in[7:0]),
      .target (target_vec[g]),
      .current(current_vec[g]),
      .pwm    (pwm[g])
    );
  end

endmodule
